// File: rtl/pipe_exe_div.sv
// Iterative 32-bit DIV/DIVU unit for the EXE stage: 32 restoring steps, stalls the pipe while running.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes the cycle after acceptance.
module pipe_exe_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   orig_q, orig_d;
  logic                qsgn_q, qsgn_d;
  logic                rsgn_q, rsgn_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;

  logic                accept;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     sub;
  logic                ge;
  logic [DATA_W-1:0]   step_quo;
  logic [DATA_W-1:0]   step_rem;

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  assign accept = (state_q == IDLE) && start && !flush;

  // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
  // A set top bit of the shifted remainder already guarantees it exceeds any 32-bit divisor.
  assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
  assign sub      = rem_sh - {1'b0, dvs_q};
  assign ge       = rem_sh[DATA_W] | ~sub[DATA_W];
  assign step_rem = ge ? sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign step_quo = {quo_q[DATA_W-2:0], ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      qsgn_q      <= 1'b0;
      rsgn_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      qsgn_q      <= qsgn_d;
      rsgn_q      <= rsgn_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            state_d = (divisor == '0) ? DONE : RUN;
`else
            state_d = RUN;
`endif
          end
        end
        RUN:     if (cnt_q == 6'd31) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    qsgn_d      = qsgn_q;
    rsgn_d      = rsgn_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (accept) begin
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = apply_sign(dividend, is_signed & dividend[DATA_W-1]);
      dvs_d  = apply_sign(divisor, is_signed & divisor[DATA_W-1]);
      orig_d = dividend;
      qsgn_d = is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      rsgn_d = is_signed & dividend[DATA_W-1];
      dz_d   = (divisor == '0);
    end else if (state_q == RUN && !flush) begin
      cnt_d = cnt_q + 6'd1;
      quo_d = step_quo;
      rem_d = step_rem;
    end
    // Results are committed on entry to DONE so they are valid alongside the done pulse.
    if (state_q == RUN && state_d == DONE) begin
      quotient_d  = dz_q ? {DATA_W{1'b1}} : apply_sign(step_quo, qsgn_q);
      remainder_d = dz_q ? orig_q : apply_sign(step_rem, rsgn_q);
    end
`ifdef DIV_ZERO_FAST_EN
    else if (state_q == IDLE && state_d == DONE) begin
      quotient_d  = {DATA_W{1'b1}};
      remainder_d = dividend;
    end
`endif
  end

  always_comb begin
    busy      = accept || (state_q == RUN);
    done      = (state_q == DONE);
    quotient  = quotient_q;
    remainder = remainder_q;
  end

endmodule

// File: tb/tb_pipe_exe_div.sv
// Bench for pipe_exe_div: table of vectors plus random ops through a scoreboard, and
// hand-written flush / reset / back-to-back sequences with latency and busy checks.
module tb_pipe_exe_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  vec_t        tbl[14];
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_q, last_r;

  pipe_exe_div dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (sg) begin
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected done: got q=%h r=%h, expected no done", quotient, remainder);
      end else begin
        mon_e = sb_q.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
      end
    end
  end

  task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    e.q       = q;
    e.r       = r;
    sb_q.push_back(e);
    last_q    = q;
    last_r    = r;
  endtask

  // Called in the acceptance cycle; holds start like the ID/EXE register until done.
  task automatic measure(input int lat, input string nm);
    int busy_cnt = 0;
    int done_at  = -1;
    for (int k = 0; k <= 40; k++) begin
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, " done latency"}, done_at, lat);
    check({nm, " busy cycles"}, busy_cnt, (lat == 1) ? 1 : 33);
  endtask

  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input string nm);
    @(negedge clk);
    drive(sg, a, b, q, r);
    measure((b == 32'd0) ? ZLAT : 33, nm);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic sg;
    logic [31:0] a, b;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    tbl[3]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
    tbl[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    tbl[5]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    tbl[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tbl[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    tbl[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    tbl[9]  = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1};
    tbl[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    tbl[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
    tbl[12] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    tbl[13] = '{1'b0, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    dividend = '0; divisor = '0; last_q = '0; last_r = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      do_op(tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd3;
      e  = model(sg, a, b);
      do_op(sg, a, b, e.q, e.r, $sformatf("rand%0d", i));
    end

    // Signed overflow, then a new DIVU offered during DONE: ignored there, accepted next cycle.
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "ovf");
    drive(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    #1;
    check("busy with start in DONE", {31'd0, busy}, 32'd0);
    @(negedge clk);
    measure(33, "b2b");

    // Flush wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5;
    #1;
    check("flush idle busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush idle not accepted", {31'd0, busy}, 32'd0);

    // Flush mid-run at T+10, restart at T+11.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush busy low", {31'd0, busy}, 32'd0);
    check("flush q kept", quotient, last_q);
    check("flush r kept", remainder, last_r);
    drive(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    measure(33, "after flush");

    // Reset asserted between edges at T+5.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF_FC18; divisor = 32'd7;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1; start = 1'b0;
    #1;
    check("midrun reset quotient", quotient, 32'd0);
    check("midrun reset remainder", remainder, 32'd0);
    check("midrun reset done", {31'd0, done}, 32'd0);
    check("midrun reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    measure(33, "post reset");

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_exe_div.md
PIPE_EXE_DIV -- requirements
Module: pipe_exe_div

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EXE-stage DIV/DIVU present, held by the ID/EXE register.
- is_signed  input  1  1 = DIV, 0 = DIVU.
- dividend  input  32  rs value.
- divisor  input  32  rt value.
- flush  input  1  synchronous abort of the EXE-stage instruction.
- busy  output  1  stall request: forces IF/ID and ID/EXE write-enable low and holds PC.
- done  output  1  one-cycle pulse, result valid.
- quotient  output  32  LO result.
- remainder  output  32  HI result.

REQ-002 Reset SHALL be reset (asynchronous, active-high); the clock SHALL be clk.

Function
REQ-003 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-004 In IDLE with start=1 and flush=0, the block SHALL capture |dividend|, |divisor| (absolute values only when is_signed=1), the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]), clear the iteration count, and enter RUN.
REQ-005 busy SHALL be combinational: 1 when (state=IDLE and start=1 and flush=0) or state=RUN, and 0 otherwise, including in DONE.
REQ-006 RUN SHALL perform one restoring-division step per cycle, 32 steps, using a 6-bit counter, then enter DONE.
REQ-007 Latency for start accepted in cycle T: RUN spans T+1..T+32, DONE occurs at T+33, and busy is high for T..T+32.
REQ-008 In DONE the block SHALL register quotient and remainder, pulse done=1 for exactly that cycle, and return to IDLE.
REQ-009 start SHALL be ignored while in DONE, because the instruction still occupies EXE; a new start is accepted only from IDLE.
REQ-010 Signed correction SHALL negate the magnitude quotient when the quotient sign is 1, and negate the magnitude remainder when the remainder sign is 1.
REQ-011 0x80000000 / 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000 and remainder 0x00000000.
REQ-012 For divisor=0, regardless of is_signed, the results SHALL be forced to quotient 0xFFFFFFFF and remainder equal to the original dividend.
REQ-013 quotient and remainder SHALL hold their last values until the next DONE.
REQ-014 flush=1 in any state SHALL return the FSM to IDLE on the next edge, with done=0 and the outputs unchanged; flush has priority over start.
REQ-015 Arithmetic SHALL use a 33-bit partial remainder; no other intermediate wider than 33 bits is permitted.

Reset
REQ-016 Asserting reset SHALL immediately force state=IDLE, done=0, quotient=0, remainder=0, counter=0 and all internal operand registers to 0.
REQ-017 Reset asserted mid-RUN SHALL abort the division with no done pulse; after release, the block SHALL accept start on the first rising edge.

Configuration
REQ-018 The block SHALL support the macro DIV_ZERO_FAST_EN.
- Defined: divisor=0 at acceptance goes IDLE->DONE directly, so done occurs at T+1 and busy is high for cycle T only.
- Undefined: divisor=0 runs all 32 iterations, with done at T+33.
- Result values (REQ-012) SHALL be identical in both builds.

Verification
REQ-019 Unsigned divide: DIVU 100/7 -> quotient 14, remainder 2; busy high for 33 cycles; done at T+33.
REQ-020 Signed divide: DIV -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-021 Signed overflow: DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; then a back-to-back DIVU 9/3 is accepted the cycle after DONE -> quotient 3, remainder 0.
REQ-022 Divide by zero: DIVU 5/0 -> quotient 0xFFFFFFFF, remainder 5; done at T+1 with DIV_ZERO_FAST_EN defined, T+33 without.
REQ-023 Flush mid-run: flush at T+10 of 1000/3 -> busy low at T+11, no done pulse, outputs retain prior values; a new start at T+11 completes normally.
REQ-024 Reset mid-run: reset asserted at T+5 (between edges) -> quotient=0, remainder=0, done=0 immediately; start after release is accepted.
